uart_hex_formatter: RTL and testbench
=====================================

Name: uart_hex_formatter

Overview:
- Converts a binary measurement word into an ASCII hex text line and streams it byte-by-byte into the UART transmitter over its send/to_send/tx_done handshake.
- Sits directly upstream of the tx stage. It is clocked by the same clock as tx, the baud clock, wired to this block's clk.
- Gives the analyzer a fire-and-forget strobe interface for reporting values, plus one-deep pending buffering and sticky error flags.

Parameters:
- DIGITS, 4, number of hex digits emitted; value width is 4*DIGITS.
- PREFIX, 8'h00, leading character sent before the digits; 8'h00 means no prefix byte.
- CRLF, 1, when 1 append 8'h0D then 8'h0A after the digits.
- TIMEOUT, 32, clk cycles allowed in ARM plus SEND for one byte before abort.

Ports:
- clk  in  1  baud-domain clock, shared with tx.
- reset  in  1  asynchronous, active-low reset.
- val_in  in  4*DIGITS  value to report, sampled when val_stb=1.
- val_stb  in  1  single-cycle request to print val_in.
- clr  in  1  synchronous clear of ovf and err.
- tx_done  in  1  from tx: 1 = transmitter idle, 0 = byte in flight.
- send  out  1  request to tx; registered.
- to_send  out  8  byte to transmit; registered; held stable from ARM until WAIT_DONE exits.
- busy  out  1  1 whenever state is not IDLE or pending is valid.
- ovf  out  1  sticky: a strobe was dropped.
- err  out  1  sticky: a byte handshake timed out.

Behaviour:
- Reset, asynchronous, active-low:
  - Outputs: send=0, to_send=8'h00, busy=0, ovf=0, err=0.
  - Internals: state=IDLE, pending empty, byte index=0, timeout counter=0.
  - Reset mid-message abandons the message immediately. No further bytes are sent.
- Message byte order: optional PREFIX, then DIGITS nibbles MSB-first, then optional 0x0D, 0x0A.
  - Total length L = (PREFIX!=0) + DIGITS + 2*CRLF.
- Nibble encoding: n<10 gives 8'h30+n; n>=10 gives 8'h41+(n-10). Uppercase only.
- Capture: a val_stb accepted from IDLE latches val_in into the shadow register at that edge. The message is built only from the shadow, so later changes on val_in have no effect.
- State machine:
  - IDLE:
    - Pending valid: load pending into shadow, clear pending, go ARM. This takes priority over a same-cycle val_stb.
    - Pending empty and val_stb=1: load shadow, go ARM.
  - ARM:
    - send=0; to_send = byte[index].
    - tx_done=1: go SEND.
  - SEND:
    - send=1.
    - tx_done=0 sampled: go WAIT_DONE and deassert send. This counts as acceptance by tx.
  - WAIT_DONE:
    - send=0.
    - tx_done=1 and index=L-1: index=0, go IDLE.
    - tx_done=1 otherwise: index++, go ARM.
- Latency: a strobe in IDLE at edge n puts state in ARM after n. If tx_done=1, send rises after edge n+1.
- Strobe while not IDLE:
  - Pending empty: store into pending.
  - Pending full: drop the new value and set ovf. The stored pending value is kept.
- Strobe in the same cycle that WAIT_DONE finishes the last byte: goes to pending, then starts on the next IDLE cycle.
- Timeout:
  - Counter clears on entry to ARM and increments each cycle in ARM or SEND.
  - Reaching TIMEOUT: set err, drive send=0, index=0, go IDLE. The current message is aborted and pending is retained.
- clr=1 clears ovf and err. A set event in the same cycle as clr wins, so the flag stays 1.
- Width rule: the index counter is wide enough for L; it never wraps within a message.

Test Plan:
- Basic line: reset, DIGITS=4, PREFIX=0, CRLF=1, tx model idle. Strobe val_in=16'h1A3F.
  - Required: bytes 0x31,0x41,0x33,0x46,0x0D,0x0A in order, one handshake each.
  - Required: busy falls after the 0x0A tx_done rise.
- Prefix and digit edges: PREFIX="V", strobe 16'h09FA.
  - Required: bytes 0x56,0x30,0x39,0x46,0x41,0x0D,0x0A.
  - Repeat with 16'hFFFF: digit bytes are all 0x46. Repeat with 16'h0000: digit bytes are all 0x30.
- Pending and overflow: strobe 16'h1111, then 16'h2222 and 16'h3333 during the first message.
  - Required: line "1111" then line "2222"; 3333 never sent; ovf=1.
  - Then clr=1: ovf returns to 0.
- Handshake hold: tx model holds tx_done=1 for 5 cycles after send rises.
  - Required: send and to_send stay stable throughout; to_send unchanged until tx_done returns high.
- Timeout: tx model never drops tx_done after send rises.
  - Required: after TIMEOUT=32 cycles err=1, send=0, state IDLE.
  - A subsequent strobe sends a full, correct line.
- Reset mid-message: assert reset during byte 3.
  - Required: send=0, busy=0, ovf=0, err=0 immediately; no bytes after reset release without a new strobe.

Source files
------------

// File: rtl/uart_hex_formatter.sv
// Formats a binary value as an uppercase ASCII hex line and streams it to the
// UART transmitter one byte per send/tx_done handshake, with a one-deep pending slot.
module uart_hex_formatter #(
   parameter int         DIGITS  = 4,
   parameter logic [7:0] PREFIX  = 8'h00,
   parameter bit         CRLF    = 1'b1,
   parameter int         TIMEOUT = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DIGITS-1:0] val_in,
   input  logic                val_stb,
   input  logic                clr,
   input  logic                tx_done,
   output logic                send,
   output logic [7:0]          to_send,
   output logic                busy,
   output logic                ovf,
   output logic                err
);

   localparam int VW  = 4*DIGITS;
   localparam int PFX = (PREFIX != 8'h00) ? 1 : 0;
   localparam int L   = PFX + DIGITS + (CRLF ? 2 : 0);
   localparam int IW  = $clog2(L+1);
   localparam int TW  = $clog2(TIMEOUT+1);

   typedef enum logic [1:0] {IDLE, ARM, SEND, WAIT_DONE} state_e;

   state_e          state_q, state_d;
   logic [VW-1:0]   shadow_q, shadow_d;
   logic [VW-1:0]   pend_q, pend_d;
   logic            pend_vld_q, pend_vld_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            send_q, send_d;
   logic [7:0]      to_send_q, to_send_d;
   logic            ovf_q, ovf_d;
   logic            err_q, err_d;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte layout: [prefix] digits MSB-first [CR LF]
   function automatic logic [7:0] byte_at(input logic [IW-1:0] idx, input logic [VW-1:0] v);
      int d;
      d = int'(idx) - PFX;
      if (d < 0)       return PREFIX;
      if (d < DIGITS)  return hex_char(v[4*(DIGITS-1-d) +: 4]);
      if (d == DIGITS) return 8'h0D;
      return 8'h0A;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         idx_q      <= '0;
         tmo_q      <= '0;
         send_q     <= 1'b0;
         to_send_q  <= 8'h00;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         send_q     <= send_d;
         to_send_q  <= to_send_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      logic stb_to_pend, ovf_set, err_set, tmo_hit;
      state_d     = state_q;
      shadow_d    = shadow_q;
      pend_d      = pend_q;
      pend_vld_d  = pend_vld_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      stb_to_pend = 1'b0;
      ovf_set     = 1'b0;
      err_set     = 1'b0;
      tmo_hit     = (tmo_q == TW'(TIMEOUT-1));
      case (state_q)
         IDLE: begin
            if (pend_vld_q) begin
               shadow_d    = pend_q;
               pend_vld_d  = 1'b0;
               state_d     = ARM;
               stb_to_pend = val_stb;
            end else if (val_stb) begin
               shadow_d = val_in;
               state_d  = ARM;
            end
         end
         ARM, SEND: begin
            if (tmo_hit) begin
               // Abort the line; a pending value survives and starts next
               err_set = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (state_q == ARM && tx_done)        state_d = SEND;
               else if (state_q == SEND && !tx_done) state_d = WAIT_DONE;
            end
         end
         default: begin
            if (tx_done) begin
               if (idx_q == IW'(L-1)) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = ARM;
               end
            end
         end
      endcase
      if (state_q != IDLE) stb_to_pend = val_stb;
      if (stb_to_pend) begin
         if (!pend_vld_d) begin
            pend_d     = val_in;
            pend_vld_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end
      if (state_d == ARM && state_q != ARM) tmo_d = '0;
      ovf_d = ovf_set | (ovf_q & ~clr);
      err_d = err_set | (err_q & ~clr);
   end

   always_comb begin
      send_d    = (state_d == SEND);
      to_send_d = (state_d == ARM) ? byte_at(idx_d, shadow_d) : to_send_q;
   end

   assign send    = send_q;
   assign to_send = to_send_q;
   assign busy    = (state_q != IDLE) | pend_vld_q;
   assign ovf     = ovf_q;
   assign err     = err_q;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Scoreboard bench: two formatter instances (no prefix / "V" prefix), each fed by a
// behavioural tx model; monitors pop expected bytes at every send rise.
module tb_uart_hex_formatter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [15:0] val0 = '0, val1 = '0;
  logic stb0 = 1'b0, stb1 = 1'b0;
  logic td0 = 1'b1, td1 = 1'b1;
  logic send0, send1, busy0, busy1, ovf0, ovf1, err0, err1;
  logic [7:0] ts0, ts1;

  int npass = 0, ntot = 0;
  logic [7:0] exp0[$], exp1[$];
  int rise0 = 0, rise1 = 0;
  logic never0 = 1'b0, chk_hold = 1'b0;
  int hold0 = 0;
  int hc0 = 0, bc0 = 0, hc1 = 0, bc1 = 0;

  always #5 clk = ~clk;

  uart_hex_formatter #(.DIGITS(4), .PREFIX(8'h00), .CRLF(1'b1), .TIMEOUT(32)) u_a (
    .clk(clk), .reset(rst_n), .val_in(val0), .val_stb(stb0), .clr(clr), .tx_done(td0),
    .send(send0), .to_send(ts0), .busy(busy0), .ovf(ovf0), .err(err0));

  uart_hex_formatter #(.DIGITS(4), .PREFIX(8'h56), .CRLF(1'b1), .TIMEOUT(32)) u_b (
    .clk(clk), .reset(rst_n), .val_in(val1), .val_stb(stb1), .clr(clr), .tx_done(td1),
    .send(send1), .to_send(ts1), .busy(busy1), .ovf(ovf1), .err(err1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // tx model: after seeing send, drop tx_done (optionally after a hold), stay busy 3 cycles
  task automatic tx_step(input logic s, input logic nev, input int hold,
                         inout logic td, inout int hc, inout int bc);
    if (!rst_n) begin td = 1'b1; hc = 0; bc = 0; end
    else if (!td) begin if (bc == 0) td = 1'b1; else bc--; end
    else if (s && !nev) begin
      if (hc < hold) hc++;
      else begin td = 1'b0; bc = 2; hc = 0; end
    end
  endtask

  always @(posedge clk) begin #1; tx_step(send0, never0, hold0, td0, hc0, bc0); end
  always @(posedge clk) begin #1; tx_step(send1, 1'b0, 0, td1, hc1, bc1); end

  logic sp0 = 1'b0, sp1 = 1'b0, infl = 1'b0, low = 1'b0;
  logic [7:0] cap = '0;

  always @(negedge clk) begin
    if (send0 && !sp0) begin
      rise0++;
      if (exp0.size() == 0) begin
        ntot++;
        $display("FAIL a_extra_byte: got %0h expected no byte", ts0);
      end else check("a_byte", ts0, exp0.pop_front());
      if (chk_hold) begin infl = 1'b1; cap = ts0; low = 1'b0; end
    end else if (infl) begin
      check("hold_to_send", ts0, cap);
      if (!low && td0) check("hold_send", send0, 1);
      if (!td0) low = 1'b1;
      else if (low) infl = 1'b0;
    end
    sp0 = send0;
  end

  always @(negedge clk) begin
    if (send1 && !sp1) begin
      rise1++;
      if (exp1.size() == 0) begin
        ntot++;
        $display("FAIL b_extra_byte: got %0h expected no byte", ts1);
      end else check("b_byte", ts1, exp1.pop_front());
    end
    sp1 = send1;
  end

  task automatic strobe(input int w, input logic [15:0] v);
    if (w == 0) begin val0 = v; stb0 = 1'b1; end
    else        begin val1 = v; stb1 = 1'b1; end
    @(negedge clk);
    stb0 = 1'b0; stb1 = 1'b0;
  endtask

  task automatic wait_idle(input int w, input string nm);
    int n = 0;
    while ((w == 0 ? (busy0 || !td0) : (busy1 || !td1)) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) begin ntot++; $display("FAIL %s_timeout: got busy expected idle", nm); end
    check({nm, "_all_sent"}, (w == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int rr, n;
    repeat (2) @(negedge clk);
    check("rst_send", send0, 0);
    check("rst_to_send", ts0, 8'h00);
    check("rst_busy", busy0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_err", err0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    exp0 = {exp0, 8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    strobe(0, 16'h1A3F);
    val0 = 16'h5555;
    wait_idle(0, "basic");
    check("basic_busy_low", busy0, 0);

    exp1 = {exp1, 8'h56, 8'h30, 8'h39, 8'h46, 8'h41, 8'h0D, 8'h0A};
    strobe(1, 16'h09FA);
    wait_idle(1, "pfx_09fa");
    exp1 = {exp1, 8'h56, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    strobe(1, 16'hFFFF);
    wait_idle(1, "pfx_ffff");
    exp1 = {exp1, 8'h56, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    strobe(1, 16'h0000);
    wait_idle(1, "pfx_0000");

    exp0 = {exp0, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A,
                  8'h32, 8'h32, 8'h32, 8'h32, 8'h0D, 8'h0A};
    strobe(0, 16'h1111);
    strobe(0, 16'h2222);
    strobe(0, 16'h3333);
    wait_idle(0, "pending");
    check("ovf_set", ovf0, 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("ovf_clr", ovf0, 0);

    hold0 = 5; chk_hold = 1'b1;
    exp0 = {exp0, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    strobe(0, 16'hBEEF);
    wait_idle(0, "hold");
    chk_hold = 1'b0; hold0 = 0;

    never0 = 1'b1;
    exp0 = {exp0, 8'h31};
    strobe(0, 16'h1234);
    repeat (31) @(negedge clk);
    check("tmo_err_early", err0, 0);
    @(negedge clk);
    check("tmo_err", err0, 1);
    check("tmo_send", send0, 0);
    check("tmo_busy", busy0, 0);
    never0 = 1'b0;
    repeat (2) @(negedge clk);
    exp0 = {exp0, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    strobe(0, 16'h5678);
    wait_idle(0, "after_tmo");
    check("err_sticky", err0, 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("err_clr", err0, 0);

    rr = rise0;
    exp0 = {exp0, 8'h43, 8'h41, 8'h46};
    strobe(0, 16'hCAFE);
    strobe(0, 16'hAAAA);
    strobe(0, 16'hBBBB);
    n = 0;
    while (rise0 < rr + 3 && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) begin ntot++; $display("FAIL rst_mid_wait: got %0d bytes expected 3", rise0 - rr); end
    check("rst_mid_ovf_before", ovf0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_send", send0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_ovf", ovf0, 0);
    check("rst_mid_err", err0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_bytes", rise0 - rr, 3);
    check("rst_idle", busy0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
